// File: rtl/timer_pkg.sv
// ============================================================================
// timer_pkg : access-size encodings, register offsets and lane helpers shared
//             by the timer peripheral core and its counter.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } access_size_e;

    localparam logic [4:0] OFF_MTIME_LO = 5'h00;
    localparam logic [4:0] OFF_MTIME_HI = 5'h04;
    localparam logic [4:0] OFF_CMP_LO   = 5'h08;
    localparam logic [4:0] OFF_CMP_HI   = 5'h0C;
    localparam logic [4:0] OFF_CTRL     = 5'h10;
    localparam logic [4:0] OFF_STATUS   = 5'h14;
    localparam logic [4:0] WINDOW_LAST  = 5'h17;

    function automatic logic [4:0] lane_shift(logic [1:0] lane);
        return {lane, 3'b000};
    endfunction

    function automatic logic [3:0] lane_be(access_size_e sz, logic [1:0] lane);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001;
            SZ_HALF: be = 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be << lane;
    endfunction

    function automatic logic [31:0] lane_align(logic [31:0] data, logic [1:0] lane);
        return data << lane_shift(lane);
    endfunction

    function automatic logic [31:0] lane_extract(logic [31:0] word, access_size_e sz,
                                                 logic [1:0] lane, logic zext);
        logic [31:0] v;
        v = word >> lane_shift(lane);
        case (sz)
            SZ_BYTE: v = zext ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
            SZ_HALF: v = zext ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] be_merge(logic [31:0] old, logic [31:0] data,
                                             logic [3:0] be);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = data[8*i +: 8];
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_counter.sv
// ============================================================================
// timer_counter : prescaler plus 64-bit MTIME with byte-lane write port.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module timer_counter
    import timer_pkg::*;
#(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick_en_i,
    input  logic [PRESCALE_W-1:0] div_i,
    input  logic                  presc_clr_i,
    input  logic [7:0]            wr_be_i,
    input  logic [63:0]           wr_data_i,
    output logic [63:0]           mtime_o
);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [63:0]           mtime_q, mtime_d;
    logic                  w_tick;

    always_comb begin
        w_tick  = tick_en_i && (presc_q == div_i);
        presc_d = presc_q;
        if (tick_en_i) presc_d = w_tick ? '0 : presc_q + PRESCALE_W'(1);
        if (presc_clr_i) presc_d = '0;

        // A store wins over a coincident tick so no carry leaks into the other half.
        if (|wr_be_i) begin
            mtime_d = {be_merge(mtime_q[63:32], wr_data_i[63:32], wr_be_i[7:4]),
                       be_merge(mtime_q[31:0],  wr_data_i[31:0],  wr_be_i[3:0])};
        end else if (w_tick) begin
            mtime_d = mtime_q + 64'd1;
        end else begin
            mtime_d = mtime_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            mtime_q <= '0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;

endmodule

`default_nettype wire

// File: rtl/timer_peripheral.sv
// ============================================================================
// timer_peripheral : memory-mapped MTIME/MTIMECMP timer with level interrupt.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module timer_peripheral
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
    parameter int          PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable_n,
    input  logic        is_write,
    input  logic        is_unsigned,
    input  logic [1:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] in,
    output logic [31:0] out,
    output logic        op_fault,
    output logic        addr_fault,
    output logic        access_fault_n,
    output logic        ext_int
);

    localparam logic [31:0] CTRL_MASK = {{(24 - PRESCALE_W){1'b0}}, {PRESCALE_W{1'b1}}, 8'h03};
    localparam logic [3:0]  DIV_LANES = {PRESCALE_W > 16, PRESCALE_W > 8, 1'b1, 1'b0};

    access_size_e w_size;
    logic         w_sel, w_in_win, w_access, w_wr, w_pend, w_presc_clr;
    logic [4:0]   w_reg;
    logic [3:0]   w_be;
    logic [7:0]   w_mt_be;
    logic [31:0]  w_wdata, w_rdata, w_ctrl_new;
    logic [63:0]  w_mtime;

    logic [63:0]  cmp_q, cmp_d;
    logic [31:0]  ctrl_q, ctrl_d;
    logic         ext_int_q, ext_int_d;

    assign w_size   = access_size_e'(op);
    assign w_sel    = !enable_n;
    assign w_reg    = {addr[4:2], 2'b00};
    assign w_in_win = (addr[31:5] == BASE_ADDR[31:5]) && (addr[4:0] <= WINDOW_LAST);

    assign op_fault       = w_sel && (w_size == SZ_ILLEGAL);
    assign addr_fault     = w_sel && (((w_size == SZ_HALF) && addr[0]) ||
                                      ((w_size == SZ_WORD) && (addr[1:0] != 2'b00)));
    assign access_fault_n = !(w_sel && !w_in_win);
    assign w_access       = w_sel && !op_fault && !addr_fault && access_fault_n;
    assign w_wr           = w_access && is_write;

    assign w_be       = lane_be(w_size, addr[1:0]);
    assign w_wdata    = lane_align(in, addr[1:0]);
    assign w_ctrl_new = be_merge(ctrl_q, w_wdata, w_be) & CTRL_MASK;
    assign w_pend     = (w_mtime >= cmp_q);

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            OFF_MTIME_LO: w_rdata = w_mtime[31:0];
            OFF_MTIME_HI: w_rdata = w_mtime[63:32];
            OFF_CMP_LO:   w_rdata = cmp_q[31:0];
            OFF_CMP_HI:   w_rdata = cmp_q[63:32];
            OFF_CTRL:     w_rdata = ctrl_q;
            OFF_STATUS:   w_rdata = {31'h0, w_pend};
            default:      ;
        endcase
    end

    assign out = (w_access && !is_write) ? lane_extract(w_rdata, w_size, addr[1:0], is_unsigned)
                                         : '0;

    // STATUS falls through the default arm, so stores there are silently dropped.
    always_comb begin
        cmp_d       = cmp_q;
        ctrl_d      = ctrl_q;
        w_mt_be     = '0;
        w_presc_clr = 1'b0;
        if (w_wr) begin
            case (w_reg)
                OFF_MTIME_LO: w_mt_be = {4'b0000, w_be};
                OFF_MTIME_HI: w_mt_be = {w_be, 4'b0000};
                OFF_CMP_LO:   cmp_d[31:0]  = be_merge(cmp_q[31:0],  w_wdata, w_be);
                OFF_CMP_HI:   cmp_d[63:32] = be_merge(cmp_q[63:32], w_wdata, w_be);
                OFF_CTRL: begin
                    ctrl_d      = w_ctrl_new;
                    w_presc_clr = |(w_be & DIV_LANES);
                end
                default: ;
            endcase
        end
        ext_int_d = ctrl_q[1] && w_pend;
    end

    timer_counter #(
        .PRESCALE_W (PRESCALE_W)
    ) u_counter (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick_en_i   (ctrl_q[0]),
        .div_i       (ctrl_q[8 +: PRESCALE_W]),
        .presc_clr_i (w_presc_clr),
        .wr_be_i     (w_mt_be),
        .wr_data_i   ({w_wdata, w_wdata}),
        .mtime_o     (w_mtime)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmp_q     <= '1;
            ctrl_q    <= '0;
            ext_int_q <= 1'b0;
        end else begin
            cmp_q     <= cmp_d;
            ctrl_q    <= ctrl_d;
            ext_int_q <= ext_int_d;
        end
    end

    assign ext_int = ext_int_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_peripheral.sv
// ============================================================================
// tb_timer_peripheral : directed plus randomized checks of timer_peripheral
//                       against a byte/arithmetic reference model.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_timer_peripheral;

    localparam logic [31:0] BASE = 32'hF000_0000;

    logic        clk;
    logic        reset_n;
    logic        enable_n;
    logic        is_write;
    logic        is_unsigned;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        op_fault;
    logic        addr_fault;
    logic        access_fault_n;
    logic        ext_int;

    timer_peripheral #(
        .BASE_ADDR  (BASE),
        .PRESCALE_W (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable_n       (enable_n),
        .is_write       (is_write),
        .is_unsigned    (is_unsigned),
        .op             (op),
        .addr           (addr),
        .in             (din),
        .out            (dout),
        .op_fault       (op_fault),
        .addr_fault     (addr_fault),
        .access_fault_n (access_fault_n),
        .ext_int        (ext_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state
    logic [63:0] m_mtime, m_cmp;
    bit          m_en, m_ie, m_ext;
    int          m_div, m_presc;

    logic [31:0] last_out;
    logic        last_opf, last_af, last_accn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mtime = 64'h0;
        m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
        m_en    = 1'b0;
        m_ie    = 1'b0;
        m_div   = 0;
        m_presc = 0;
        m_ext   = 1'b0;
    endtask

    function automatic logic [31:0] m_word(input int k);
        case (k)
            0:       return m_mtime[31:0];
            1:       return m_mtime[63:32];
            2:       return m_cmp[31:0];
            3:       return m_cmp[63:32];
            4:       return {16'h0, 8'(m_div), 6'h0, m_ie, m_en};
            5:       return {31'h0, m_mtime >= m_cmp};
            default: return 32'h0;
        endcase
    endfunction

    // One rising edge of the model: tick from pre-edge EN/DIV, store, interrupt from pre-edge state.
    task automatic m_edge(input bit store, input logic [31:0] a, input logic [31:0] d, input int nb);
        bit          tick, mt_wr, ext_next;
        int          np, off, k, lane;
        logic [31:0] w;
        tick     = m_en && (m_presc == m_div);
        ext_next = m_ie && (m_mtime >= m_cmp);
        np       = m_en ? (tick ? 0 : m_presc + 1) : m_presc;
        mt_wr    = 1'b0;
        if (store) begin
            off  = int'(a - BASE);
            k    = off / 4;
            lane = off % 4;
            w    = m_word(k);
            for (int i = 0; i < nb; i++) w[8*(lane+i) +: 8] = d[8*i +: 8];
            case (k)
                0: begin m_mtime[31:0]  = w; mt_wr = 1'b1; end
                1: begin m_mtime[63:32] = w; mt_wr = 1'b1; end
                2: m_cmp[31:0]  = w;
                3: m_cmp[63:32] = w;
                4: begin
                    m_en  = w[0];
                    m_ie  = w[1];
                    m_div = int'(w[15:8]);
                    if (lane <= 1 && lane + nb > 1) np = 0;
                end
                default: ;
            endcase
        end
        if (!mt_wr && tick) m_mtime = m_mtime + 64'd1;
        m_presc = np;
        m_ext   = ext_next;
    endtask

    // One bus cycle: drive, check combinational outputs, clock, check ext_int.
    task automatic cyc(input bit en_n, input bit wr, input bit uns, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] d);
        bit          e_opf, e_af, e_accn, win, fault;
        int          nb, off;
        logic [63:0] v, mask;
        logic [31:0] exp_out;
        enable_n    = en_n;
        is_write    = wr;
        is_unsigned = uns;
        op          = o;
        addr        = a;
        din         = d;
        #2;
        win     = (a >= BASE) && ((a - BASE) < 32'd24);
        e_opf   = !en_n && (o == 2'b11);
        e_af    = !en_n && (((o == 2'b01) && a[0]) || ((o == 2'b10) && (a[1:0] != 2'b00)));
        e_accn  = !(!en_n && !win);
        fault   = e_opf || e_af || !e_accn;
        nb      = 1 << o;
        exp_out = 32'h0;
        if (!en_n && !wr && !fault) begin
            off  = int'(a - BASE);
            v    = {32'h0, m_word(off / 4)} >> (8 * (off % 4));
            mask = (64'd1 << (8 * nb)) - 64'd1;
            v    = v & mask;
            if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
            exp_out = v[31:0];
        end
        chk("out", dout, exp_out);
        chk("op_fault", {31'h0, op_fault}, {31'h0, e_opf});
        chk("addr_fault", {31'h0, addr_fault}, {31'h0, e_af});
        chk("access_fault_n", {31'h0, access_fault_n}, {31'h0, e_accn});
        last_out  = dout;
        last_opf  = op_fault;
        last_af   = addr_fault;
        last_accn = access_fault_n;
        @(posedge clk);
        m_edge(!en_n && wr && !fault, a, d, nb);
        #1;
        chk("ext_int", {31'h0, ext_int}, {31'h0, m_ext});
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b0, 2'b10, a, d);
    endtask

    task automatic rd32(input logic [31:0] a);
        cyc(1'b0, 1'b0, 1'b0, 2'b10, a, 32'h0);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    initial begin
        reset_n     = 1'b0;
        enable_n    = 1'b1;
        is_write    = 1'b0;
        is_unsigned = 1'b0;
        op          = 2'b00;
        addr        = 32'h0;
        din         = 32'h0;
        m_reset();
        #2;
        chk("reset_ext_int", {31'h0, ext_int}, 32'h0);
        chk("reset_out_idle", dout, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset values
        rd32(BASE + 32'h08);
        chk("rst_cmp_lo", last_out, 32'hFFFF_FFFF);
        rd32(BASE + 32'h0C);
        chk("rst_cmp_hi", last_out, 32'hFFFF_FFFF);
        rd32(BASE + 32'h10);
        chk("rst_ctrl", last_out, 32'h0);

        // Prescaler DIV=3: one tick per four clocks
        wr32(BASE + 32'h10, 32'h0000_0301);
        for (int i = 0; i < 40; i++) idle();
        rd32(BASE + 32'h00);
        chk("div3_mtime_40clk", last_out, 32'd10);

        // Compare interrupt
        wr32(BASE + 32'h10, 32'h0);
        wr32(BASE + 32'h00, 32'h0);
        wr32(BASE + 32'h04, 32'h0);
        wr32(BASE + 32'h08, 32'd5);
        wr32(BASE + 32'h0C, 32'h0);
        wr32(BASE + 32'h10, 32'h0000_0003);
        for (int i = 0; i < 5; i++) idle();
        chk("ext_before", {31'h0, ext_int}, 32'h0);
        idle();
        chk("ext_rise", {31'h0, ext_int}, 32'h1);
        idle();
        chk("ext_no_selfclear", {31'h0, ext_int}, 32'h1);
        wr32(BASE + 32'h08, 32'd100);
        chk("ext_hold", {31'h0, ext_int}, 32'h1);
        idle();
        chk("ext_drop", {31'h0, ext_int}, 32'h0);

        // Carry into the high word, and store-over-tick priority
        wr32(BASE + 32'h10, 32'h0);
        wr32(BASE + 32'h00, 32'hFFFF_FFFF);
        wr32(BASE + 32'h04, 32'h0);
        wr32(BASE + 32'h10, 32'h1);
        rd32(BASE + 32'h04);
        rd32(BASE + 32'h04);
        chk("carry_hi", last_out, 32'h1);
        wr32(BASE + 32'h10, 32'h0);
        wr32(BASE + 32'h00, 32'hFFFF_FFFF);
        wr32(BASE + 32'h04, 32'h0);
        wr32(BASE + 32'h10, 32'h1);
        wr32(BASE + 32'h00, 32'h0);
        rd32(BASE + 32'h04);
        chk("no_carry_on_store", last_out, 32'h0);

        // 64-bit wrap
        wr32(BASE + 32'h10, 32'h0);
        wr32(BASE + 32'h00, 32'hFFFF_FFFF);
        wr32(BASE + 32'h04, 32'hFFFF_FFFF);
        wr32(BASE + 32'h10, 32'h1);
        idle();
        wr32(BASE + 32'h10, 32'h0);
        rd32(BASE + 32'h04);
        chk("wrap_hi", last_out, 32'h0);

        // Faults leave state untouched
        rd32(BASE + 32'h02);
        chk("misaligned_af", {31'h0, last_af}, 32'h1);
        chk("misaligned_out", last_out, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 2'b11, BASE + 32'h10, 32'h0);
        chk("illegal_op", {31'h0, last_opf}, 32'h1);
        rd32(BASE + 32'h18);
        chk("out_of_window", {31'h0, last_accn}, 32'h0);
        wr32(BASE + 32'h0A, 32'hDEAD_BEEF);
        cyc(1'b0, 1'b1, 1'b0, 2'b11, BASE + 32'h08, 32'h1234_5678);
        wr32(BASE + 32'h18, 32'hCAFE_F00D);
        cyc(1'b0, 1'b1, 1'b0, 2'b01, BASE + 32'h09, 32'h0000_5555);
        wr32(BASE + 32'h14, 32'hFFFF_FFFF);
        chk("status_store_nofault", {31'h0, last_accn}, 32'h1);
        rd32(BASE + 32'h08);
        chk("fault_nomod_cmp", last_out, 32'd100);

        // Narrow store and sign/zero-extended loads
        cyc(1'b0, 1'b1, 1'b0, 2'b00, BASE + 32'h01, 32'h0000_0080);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, BASE + 32'h01, 32'h0);
        chk("byte_signed", last_out, 32'hFFFF_FF80);
        cyc(1'b0, 1'b0, 1'b1, 2'b00, BASE + 32'h01, 32'h0);
        chk("byte_unsigned", last_out, 32'h0000_0080);

        // Asynchronous reset clears a pending interrupt without a clock edge
        wr32(BASE + 32'h08, 32'h0);
        wr32(BASE + 32'h0C, 32'h0);
        wr32(BASE + 32'h10, 32'h2);
        idle();
        chk("ext_pre_reset", {31'h0, ext_int}, 32'h1);
        enable_n = 1'b1;
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_reset_ext", {31'h0, ext_int}, 32'h0);
        enable_n = 1'b0;
        is_write = 1'b0;
        op       = 2'b10;
        addr     = BASE + 32'h08;
        #1;
        chk("load_during_reset", dout, 32'hFFFF_FFFF);
        enable_n = 1'b1;
        m_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        rd32(BASE + 32'h10);
        chk("post_reset_ctrl", last_out, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [1:0]  o;
            logic [31:0] a;
            int          sel, lane;
            o   = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                a = $urandom;
            end else if (sel == 1) begin
                a = BASE + 32'($urandom_range(24, 31));
            end else begin
                lane = int'($urandom_range(0, 3));
                if ($urandom_range(0, 7) != 0) begin
                    if (o == 2'b01) lane = lane & 2;
                    else if (o == 2'b10) lane = 0;
                end
                a = BASE + 32'(int'($urandom_range(0, 5)) * 4 + lane);
            end
            cyc(($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), o, a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
